reg_bank_arbiter: RTL and testbench
===================================

Name: reg_bank_arbiter

Overview:
- Two-requester round-robin arbiter that owns a shared WIDTH-bit D-flip-flop register bank and its complement output.
- Grants exclusive write access to one requester at a time; only the granted requester's write strobe reaches the register.
- Sits between two producer blocks and the shared storage register. All outputs are registered.

Parameters:
- WIDTH, 8, data width of the shared register bank.
- CNT_W, 8, width of the saturating write counter.
- MAX_HOLD, 4, maximum consecutive grant cycles while the other side waits (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- req0  input  1  requester 0 access request, level-sensitive
- req1  input  1  requester 1 access request, level-sensitive
- we0  input  1  requester 0 write strobe
- we1  input  1  requester 1 write strobe
- wdata0  input  WIDTH  requester 0 write data
- wdata1  input  WIDTH  requester 1 write data
- gnt0  output  1  requester 0 owns the register
- gnt1  output  1  requester 1 owns the register
- q  output  WIDTH  register contents
- q_bar  output  WIDTH  bitwise complement of q
- owner  output  1  id of the last successful writer
- wr_count  output  CNT_W  successful writes, saturating

Behaviour:
- Reset (reset=0, asynchronous assert):
  - State IDLE; gnt0=gnt1=0.
  - q=0, q_bar=all ones, owner=0, wr_count=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - Release is synchronous to the next rising clk edge.
- States:
  - IDLE
    - req0 only -> OWN0.
    - req1 only -> OWN1.
    - Both -> OWN of the side not equal to last; then last updates to that side.
  - OWN0
    - Stay while req0=1.
    - req0=0 and req1=1 -> OWN1 directly, with no IDLE bubble.
    - req0=0 and req1=0 -> IDLE.
  - OWN1: symmetric to OWN0.
- Latency:
  - Grant asserts on the first rising edge after the request is sampled: 1-cycle request-to-grant.
  - Grant drops on the edge at which req=0 is sampled.
- gnt0 and gnt1 are one-hot or zero. Both asserted together is illegal.
- Write:
  - At a rising edge with gntk=1 and wek=1: q<=wdatak, q_bar<=~wdatak, owner<=k, wr_count increments.
  - wek while not granted is ignored.
  - A write in the same cycle as req drop still commits, because grant is still high that cycle.
- Counter: wr_count saturates at 2^CNT_W-1 and never wraps.
- Reset mid-operation: grant, q and counters clear immediately. An in-flight write is lost.
- X on req with reset=0 has no effect.

Optional Feature:
- Macro REGARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on each grant change and counts cycles in OWNk.
  - When it reaches MAX_HOLD-1 while the other side requests, the next edge switches ownership to the other side, even if reqk stays high.
  - If the other side is not requesting, ownership continues and the counter saturates.
- Undefined: no hold counter; ownership persists until reqk drops. MAX_HOLD is unused.

Decomposition:
- Package regarb_pkg holds:
  - State enum: IDLE, OWN0, OWN1.
  - Default WIDTH and CNT_W constants.
  - Requester id constants REQ0=0, REQ1=1.
- One sub-module, reg_bank_cell: WIDTH-bit enable flop bank with async active-low clear, producing q and q_bar. The arbiter FSM, pointer and counters stay in the top module.

Test Plan:
- Reset and single requester:
  - Stimulus: reset=0 for 2 cycles, release; req0=1 with we0=1, wdata0=8'hA5.
  - Response: before grant, gnt0=0 and q=8'h00, q_bar=8'hFF. After 1 cycle gnt0=1; next edge q=8'hA5, q_bar=8'h5A, owner=0, wr_count=1.
- Tie after reset:
  - Stimulus: req0=req1=1 from IDLE.
  - Response: gnt0=1 first. After req0 drops, gnt1=1 on the next edge with no IDLE cycle. A later tie from IDLE grants requester 0 again (last=1 after OWN1).
- Ungranted write blocked:
  - Stimulus: gnt1=1; we0=1, wdata0=8'h3C; we1=1, wdata1=8'hC3.
  - Response: q=8'hC3, owner=1; the 8'h3C write is never visible.
- Counter saturation:
  - Stimulus: CNT_W=4, 20 granted writes.
  - Response: wr_count stops at 15.
- Timeout (REGARB_TIMEOUT_EN, MAX_HOLD=4):
  - Stimulus: req0 held high, req1 asserted 1 cycle after gnt0.
  - Response: gnt0 high for exactly 4 cycles, then gnt1=1.
  - Without the macro, gnt0 persists until req0 drops.
- Reset mid-grant:
  - Stimulus: assert reset between edges while gnt1=1 and q=8'h77.
  - Response: gnt1=0 and q=8'h00 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/regarb_pkg.sv
// Shared types and constants for the two-requester register bank arbiter.
package regarb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/reg_bank_cell.sv
// WIDTH-bit enable flop bank with async active-low clear; drives q and its complement.
module reg_bank_cell #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] q_bar_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_bar_q;

    // Complement is stored, not derived, so both outputs are flop-driven.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q     <= '0;
            q_bar_q <= '1;
        end else if (en_i) begin
            q_q     <= d_i;
            q_bar_q <= ~d_i;
        end
    end

    assign q_o     = q_q;
    assign q_bar_o = q_bar_q;

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin two-requester arbiter owning a shared register bank.
// Optional hold-timeout fairness is enabled with `define REGARB_TIMEOUT_EN.
module reg_bank_arbiter
    import regarb_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             owner,
    output logic [CNT_W-1:0] wr_count
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    state_e           state_q, state_d;
    logic             gnt0_q, gnt1_q;
    logic             last_q;
    logic             owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic [HOLD_W-1:0] hold_q;
    logic             hold_expired;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;

`ifdef REGARB_TIMEOUT_EN
    assign hold_expired = (hold_q == HOLD_W'(MAX_HOLD - 1));
`else
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req0 && (!req1 || last_q == REQ1)) state_d = OWN0;
                else if (req1)                         state_d = OWN1;
            end
            OWN0: begin
                if (!req0)                     state_d = req1 ? OWN1 : IDLE;
                else if (req1 && hold_expired) state_d = OWN1;
            end
            OWN1: begin
                if (!req1)                     state_d = req0 ? OWN0 : IDLE;
                else if (req0 && hold_expired) state_d = OWN0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grants are registered copies of the next state; last tracks every new owner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            last_q  <= REQ1;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt0_q  <= (state_d == OWN0);
            gnt1_q  <= (state_d == OWN1);
            if (state_d != state_q) begin
                hold_q <= '0;
                if (state_d != IDLE) last_q <= (state_d == OWN1) ? REQ1 : REQ0;
            end else if (state_q != IDLE && !hold_expired) begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end

    // Only the granted side's strobe can reach the bank.
    assign wr_en   = (gnt0_q && we0) || (gnt1_q && we1);
    assign wr_data = gnt1_q ? wdata1 : wdata0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= REQ0;
            cnt_q   <= '0;
        end else if (wr_en) begin
            owner_q <= gnt1_q ? REQ1 : REQ0;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
    end

    reg_bank_cell #(.WIDTH(WIDTH)) u_bank (
        .clk     (clk),
        .rst_n   (reset),
        .en_i    (wr_en),
        .d_i     (wr_data),
        .q_o     (q),
        .q_bar_o (q_bar)
    );

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign owner    = owner_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter (WIDTH=8, CNT_W=4, MAX_HOLD=4).
module tb_reg_bank_arbiter;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             owner;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic req0, req1, we0, we1;
    logic [WIDTH-1:0] wdata0, wdata1;
    logic gnt0, gnt1, owner;
    logic [WIDTH-1:0] q, q_bar;
    logic [CNT_W-1:0] wr_count;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    reg_bank_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
        .q(q), .q_bar(q_bar), .owner(owner), .wr_count(wr_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        {req0, req1, we0, we1} = '0;
        wdata0 = '0;
        wdata1 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_cnt = 0;
        sb.delete();
    endtask

    function automatic logic [CNT_W-1:0] bump();
        if (exp_cnt < 15) exp_cnt++;
        return CNT_W'(exp_cnt);
    endfunction

    task automatic test_reset();
        exp_t e;
        reset_dut();
        checks++;
        if ({gnt0, gnt1, q, q_bar, owner, wr_count} !== {2'b00, 8'h00, 8'hFF, 1'b0, 4'h0}) begin
            failures++;
            $display("FAIL reset_state: gnt=%b%b q=%h q_bar=%h owner=%b cnt=%0d want 00 00 ff 0 0",
                     gnt0, gnt1, q, q_bar, owner, wr_count);
        end
        req0 = 1'b1; we0 = 1'b1; wdata0 = 8'hA5;
        checks++;
        if (gnt0 !== 1'b0 || q !== 8'h00 || q_bar !== 8'hFF) begin
            failures++;
            $display("FAIL pre_grant: gnt0=%b q=%h q_bar=%h want 0 00 ff", gnt0, q, q_bar);
        end
        tick();
        checks++;
        if (gnt0 !== 1'b1 || q !== 8'h00) begin
            failures++;
            $display("FAIL grant_latency: gnt0=%b q=%h want 1 00", gnt0, q);
        end
        sb.push_back('{q: 8'hA5, owner: 1'b0, cnt: bump()});
        tick();
        e = sb.pop_front();
        checks++;
        if (q !== e.q || q_bar !== ~e.q || owner !== e.owner || wr_count !== e.cnt) begin
            failures++;
            $display("FAIL first_write: q=%h q_bar=%h owner=%b cnt=%0d want %h %h %b %0d",
                     q, q_bar, owner, wr_count, e.q, ~e.q, e.owner, e.cnt);
        end
        req0 = 1'b0; we0 = 1'b0;
        tick();
        checks++;
        if (gnt0 !== 1'b0 || wr_count !== CNT_W'(exp_cnt)) begin
            failures++;
            $display("FAIL release: gnt0=%b cnt=%0d want 0 %0d", gnt0, wr_count, exp_cnt);
        end
    endtask

    task automatic test_tie();
        reset_dut();
        req0 = 1'b1; req1 = 1'b1;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            failures++;
            $display("FAIL tie_first: gnt=%b%b want 10", gnt0, gnt1);
        end
        req0 = 1'b0;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            failures++;
            $display("FAIL handoff_no_bubble: gnt=%b%b want 01", gnt0, gnt1);
        end
        req1 = 1'b0;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b00) begin
            failures++;
            $display("FAIL idle_after_own1: gnt=%b%b want 00", gnt0, gnt1);
        end
        req0 = 1'b1; req1 = 1'b1;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            failures++;
            $display("FAIL tie_round_robin: gnt=%b%b want 10", gnt0, gnt1);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_blocked_write();
        exp_t e;
        reset_dut();
        req1 = 1'b1;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            failures++;
            $display("FAIL req1_grant: gnt=%b%b want 01", gnt0, gnt1);
        end
        we0 = 1'b1; wdata0 = 8'h3C; we1 = 1'b1; wdata1 = 8'hC3;
        sb.push_back('{q: 8'hC3, owner: 1'b1, cnt: bump()});
        tick();
        e = sb.pop_front();
        checks++;
        if (q !== e.q || q_bar !== ~e.q || owner !== e.owner || wr_count !== e.cnt) begin
            failures++;
            $display("FAIL granted_write: q=%h q_bar=%h owner=%b cnt=%0d want %h %h %b %0d",
                     q, q_bar, owner, wr_count, e.q, ~e.q, e.owner, e.cnt);
        end
        we1 = 1'b0;
        tick();
        checks++;
        if (q !== 8'hC3 || owner !== 1'b1 || wr_count !== CNT_W'(exp_cnt)) begin
            failures++;
            $display("FAIL ungranted_blocked: q=%h owner=%b cnt=%0d want c3 1 %0d",
                     q, owner, wr_count, exp_cnt);
        end
        {req1, we0} = 2'b00;
        tick();
    endtask

    task automatic test_saturation();
        exp_t e;
        reset_dut();
        req0 = 1'b1;
        tick();
        we0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wdata0 = WIDTH'(i * 13 + 1);
            sb.push_back('{q: WIDTH'(i * 13 + 1), owner: 1'b0, cnt: bump()});
            tick();
            e = sb.pop_front();
            checks++;
            if (q !== e.q || wr_count !== e.cnt) begin
                failures++;
                $display("FAIL saturation[%0d]: q=%h cnt=%0d want %h %0d", i, q, wr_count, e.q, e.cnt);
            end
        end
        {req0, we0} = 2'b00;
        tick();
    endtask

    task automatic test_hold();
        int held = 0;
        reset_dut();
        req0 = 1'b1;
        tick();
        req1 = 1'b1;
        while (gnt0 === 1'b1 && held < 12) begin
            held++;
            tick();
        end
`ifdef REGARB_TIMEOUT_EN
        checks++;
        if (held != 4 || gnt1 !== 1'b1) begin
            failures++;
            $display("FAIL hold_timeout: gnt0 cycles=%0d gnt1=%b want 4 1", held, gnt1);
        end
`else
        checks++;
        if (held != 12 || gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL hold_persist: gnt0 cycles=%0d gnt1=%b want 12 0", held, gnt1);
        end
        req0 = 1'b0;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            failures++;
            $display("FAIL hold_release: gnt=%b%b want 01", gnt0, gnt1);
        end
`endif
        {req0, req1} = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid();
        reset_dut();
        req1 = 1'b1;
        tick();
        we1 = 1'b1; wdata1 = 8'h77;
        tick();
        we1 = 1'b0;
        checks++;
        if (gnt1 !== 1'b1 || q !== 8'h77) begin
            failures++;
            $display("FAIL mid_setup: gnt1=%b q=%h want 1 77", gnt1, q);
        end
        we1 = 1'b1; wdata1 = 8'h11;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1} !== 2'b00 || q !== 8'h00 || q_bar !== 8'hFF || wr_count !== '0 || owner !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: gnt=%b%b q=%h q_bar=%h cnt=%0d owner=%b want 00 00 ff 0 0",
                     gnt0, gnt1, q, q_bar, wr_count, owner);
        end
        req1 = 1'bx;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b00 || q !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold: gnt=%b%b q=%h want 00 00", gnt0, gnt1, q);
        end
        {req1, we1} = 2'b00;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_blocked_write();
        test_saturation();
        test_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
